// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-selection path: default widths,
// output-buffer state encoding and the buffered entry layout.
package alu_pkg;

  localparam int ALU_IN_W  = 4;
  localparam int ALU_OUT_W = 8;
  localparam int ALU_N_CH  = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [ALU_OUT_W-1:0] data;
    logic                 zero;
    logic                 neg;
    logic                 err;
  } alu_entry_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry valid/ready buffer. in_ready and out_valid decode only the
// registered state, so there is no combinational path from out_ready to in_ready.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push_s;
  logic         pop_s;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Occupancy FSM; head_q is always the oldest beat, tail_q the younger one in TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            head_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_q <= in_data;
          end else if (push_s) begin
            tail_q  <= in_data;
            state_q <= TWO;
          end else if (pop_s) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (pop_s) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_sel.sv
// Selects one ALU result channel, zero/sign-extends it, derives flags and
// flags illegal selects, then hands the beat to a two-entry output buffer.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int IN_W  = ALU_IN_W,
  parameter int OUT_W = ALU_OUT_W,
  parameter int N_CH  = ALU_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*IN_W-1:0] in_data,
  input  logic [N_CH-1:0]      ext_signed,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clr_err,
  output logic                 err_sel
);

  localparam int PW = OUT_W + 3;
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  logic [IN_W-1:0]  chan_s;
  logic             sgn_s;
  logic             legal_s;
  logic [OUT_W-1:0] ext_s;
  logic             accept_s;
  logic [PW-1:0]    push_data_s;
  logic [PW-1:0]    head_s;
  logic             err_sel_q;

  assign legal_s = ({1'b0, sel} < N_CH_L);

  // One-hot AND-OR channel mux; an illegal select matches no channel and yields zero.
  always_comb begin
    chan_s = '0;
    sgn_s  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      chan_s = chan_s | (in_data[c*IN_W +: IN_W] & {IN_W{sel == SEL_W'(c)}});
      sgn_s  = sgn_s | (ext_signed[c] & (sel == SEL_W'(c)));
    end
  end

  // Extend to OUT_W; the loop form also covers OUT_W == IN_W.
  always_comb begin
    ext_s = '0;
    ext_s[IN_W-1:0] = chan_s;
    for (int b = IN_W; b < OUT_W; b++) begin
      ext_s[b] = sgn_s & chan_s[IN_W-1];
    end
  end

  assign push_data_s = {ext_s, (ext_s == '0), ext_s[OUT_W-1], ~legal_s};
  assign accept_s    = in_valid && in_ready;

  alu_skid_buf #(
    .W(PW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (push_data_s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (head_s),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data = head_s[PW-1:3];
  assign out_zero = head_s[2];
  assign out_neg  = head_s[1];
  assign out_err  = head_s[0];

  // Sticky illegal-select flag; a new illegal accept beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q <= 1'b0;
    end else if (accept_s && !legal_s) begin
      err_sel_q <= 1'b1;
    end else if (clr_err) begin
      err_sel_q <= 1'b0;
    end
  end

  assign err_sel = err_sel_q;

endmodule

// File: tb/tb_alu_result_sel.sv
// Directed vector table plus hand sequences on the default configuration, and a
// scoreboarded random-backpressure run on an 8-channel 8-to-16-bit instance.
module tb_alu_result_sel;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance (IN_W=4, OUT_W=8, N_CH=6)
  logic [23:0] in_data;
  logic [5:0]  ext_signed;
  logic [2:0]  sel;
  logic        in_valid, in_ready, out_zero, out_neg, out_err, out_valid, out_ready;
  logic        clr_err, err_sel;
  logic [7:0]  out_data;

  // Wide instance (IN_W=8, OUT_W=16, N_CH=8)
  logic [63:0] in_data2;
  logic [7:0]  ext2;
  logic [2:0]  sel2;
  logic        in_valid2, in_ready2, zero2, neg2, err2, out_valid2, out_ready2;
  logic        clr_err2, err_sel2;
  logic [15:0] out_data2;

  int total = 0;
  int bad   = 0;

  alu_result_sel dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .ext_signed(ext_signed), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_zero(out_zero),
    .out_neg(out_neg), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .clr_err(clr_err), .err_sel(err_sel)
  );

  alu_result_sel #(.IN_W(8), .OUT_W(16), .N_CH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .ext_signed(ext2), .sel(sel2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2), .out_zero(zero2),
    .out_neg(neg2), .out_err(err2), .out_valid(out_valid2), .out_ready(out_ready2),
    .clr_err(clr_err2), .err_sel(err_sel2)
  );

  typedef struct {
    logic [23:0] d;
    logic [5:0]  e;
    logic [2:0]  s;
    logic [7:0]  exp_data;
    logic        exp_zero;
    logic        exp_neg;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [23:0] d, input logic [5:0] e, input logic [2:0] s);
    in_data = d; ext_signed = e; sel = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] model2(input logic [63:0] d, input logic [7:0] e,
                                         input logic [2:0] s);
    logic [7:0] ch;
    ch = d[int'(s)*8 +: 8];
    return e[s] ? {{8{ch[7]}}, ch} : {8'h00, ch};
  endfunction

  initial begin
    vecs[0] = '{24'h000A00, 6'b000000, 3'd2, 8'h0A, 1'b0, 1'b0};
    vecs[1] = '{24'h000A00, 6'b000100, 3'd2, 8'hFA, 1'b0, 1'b1};
    vecs[2] = '{24'h000A00, 6'b111111, 3'd0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{24'h700000, 6'b111111, 3'd5, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{24'h080000, 6'b010000, 3'd4, 8'hF8, 1'b0, 1'b1};
    vecs[5] = '{24'h0000F0, 6'b000000, 3'd1, 8'h0F, 1'b0, 1'b0};
    vecs[6] = '{24'h00F000, 6'b001000, 3'd3, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{24'h000009, 6'b111110, 3'd0, 8'h09, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_data = 24'h0; ext_signed = 6'h0; sel = 3'd0; in_valid = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    in_data2 = 64'h0; ext2 = 8'h0; sel2 = 3'd0; in_valid2 = 1'b0;
    out_ready2 = 1'b0; clr_err2 = 1'b0;
    repeat (2) tick();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_zero, out_neg, out_err}), 32'd0);
    chk("rst_err_sel", 32'(err_sel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single beats
    for (int i = 0; i < 8; i++) begin
      push1(vecs[i].d, vecs[i].e, vecs[i].s);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp_zero));
      chk($sformatf("v%0d_neg", i), 32'(out_neg), 32'(vecs[i].exp_neg));
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'd0);
      tick();
      chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Illegal select and sticky flag
    chk("err_sel_init", 32'(err_sel), 32'd0);
    push1(24'hFFFFFF, 6'b111111, 3'd7);
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_data", 32'(out_data), 32'd0);
    chk("ill_flags", 32'({out_zero, out_neg, out_err}), 32'b101);
    chk("ill_err_sel", 32'(err_sel), 32'd1);
    tick();
    chk("ill_err_sel_sticky", 32'(err_sel), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_alone", 32'(err_sel), 32'd0);
    clr_err = 1'b1;
    push1(24'h123456, 6'b000000, 3'd6);
    clr_err = 1'b0;
    chk("set_beats_clear", 32'(err_sel), 32'd1);
    chk("ill6_err", 32'(out_err), 32'd1);
    tick();

    // Backpressure: A,B buffered, C held, then drained in order
    out_ready = 1'b0;
    in_data = 24'h000321; ext_signed = 6'h0; in_valid = 1'b1;
    sel = 3'd0; tick();
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    sel = 3'd1; tick();
    chk("bp_ready_two", 32'(in_ready), 32'd0);
    chk("bp_head_a", 32'(out_data), 32'h01);
    sel = 3'd2; tick();
    chk("bp_c_held", 32'(in_ready), 32'd0);
    chk("bp_head_stable", 32'(out_data), 32'h01);
    out_ready = 1'b1; tick();
    chk("bp_head_b", 32'(out_data), 32'h02);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", 32'(out_data), 32'h03);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two beats buffered
    out_ready = 1'b0;
    in_data = 24'h000321; in_valid = 1'b1;
    sel = 3'd0; tick();
    sel = 3'd1; tick();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_err_sel", 32'(err_sel), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    push1(24'h000321, 6'h0, 3'd2);
    chk("post_rst_data", 32'(out_data), 32'h03);
    tick();
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);

    // Wide instance: random data, random backpressure, scoreboard
    for (int cyc = 0; cyc < 1000; cyc++) begin
      logic acc;
      in_data2   = {$urandom, $urandom};
      ext2       = 8'($urandom);
      sel2       = 3'($urandom);
      in_valid2  = ($urandom_range(0, 7) != 0);
      out_ready2 = 1'($urandom);
      #1;
      chk("w_in_ready", 32'(in_ready2), 32'(sb.size() < 2));
      chk("w_out_valid", 32'(out_valid2), 32'(sb.size() > 0));
      acc = in_valid2 && (sb.size() < 2);
      if (sb.size() > 0 && out_ready2) begin
        chk("w_data", 32'(out_data2), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (acc) sb.push_back(model2(in_data2, ext2, sel2));
      tick();
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (sb.size() > 0) begin
        chk("w_drain_data", 32'(out_data2), 32'(sb[0]));
        void'(sb.pop_front());
      end
      tick();
    end
    chk("w_sb_empty", 32'(sb.size()), 32'd0);
    chk("w_final_valid", 32'(out_valid2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
